// File: rtl/sequenciador_morse_pkg.sv
// Shared types and constants for the digit Morse transmit path.
package pacote_morse;

   typedef enum logic [1:0] {OCIOSO, MARCA, ESPACO, FIM} estado_t;

   localparam int DOT_UNITS      = 1;
   localparam int DASH_UNITS     = 3;
   localparam int GAP_UNITS      = 1;
   localparam int CHAR_GAP_UNITS = 3;

   localparam logic [4:0] CODIGO_VAZIO = 5'b01010;

   // Only the ten digit patterns are transmittable; the encoder blank value is not.
   function automatic logic codigo_valido(input logic [4:0] c);
      logic ok;
      case (c)
         5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
         5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: ok = 1'b1;
         default:                                           ok = 1'b0;
      endcase
      if (c == CODIGO_VAZIO) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/sequenciador_morse_temporizador.sv
// Loadable down-counter timing marks and gaps; expirou is high while it reads 0.
module temporizador_morse #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             carga,
   input  logic [CNT_W-1:0] valor,
   output logic             expirou
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)               cnt_q <= '0;
      else if (carga)          cnt_q <= valor;
      else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
   end

   assign expirou = (cnt_q == '0);

endmodule

// File: rtl/sequenciador_morse.sv
// Keys a 5-symbol digit code out on led with start/busy/done handshake.
// Optional MORSE_ABORT_EN adds the aborta input to cancel a transmission.
module sequenciador_morse
   import pacote_morse::*;
#(
   parameter int UNIT_CYCLES = 4,
   parameter int N_SIMBOLOS  = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] codigo,
`ifdef MORSE_ABORT_EN
   input  logic       aborta,
`endif
   output logic       led,
   output logic       busy,
   output logic       done,
   output logic       erro,
   output logic [2:0] indice
);

   localparam int CNT_W = $clog2(3*UNIT_CYCLES+1);

   localparam logic [CNT_W-1:0] T_DOT  = CNT_W'(DOT_UNITS*UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] T_DASH = CNT_W'(DASH_UNITS*UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] T_GAP  = CNT_W'(GAP_UNITS*UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] T_CHAR = CNT_W'(CHAR_GAP_UNITS*UNIT_CYCLES - 1);
   localparam logic [2:0]       ULTIMO = 3'(N_SIMBOLOS - 1);

   estado_t          estado_q, estado_d;
   logic [4:0]       sr_q, sr_d;
   logic [2:0]       indice_q, indice_d;
   logic             led_q, led_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             erro_q, erro_d;
   logic             carga;
   logic [CNT_W-1:0] valor;
   logic             expirou;

   function automatic logic [CNT_W-1:0] dur_marca(input logic traco);
      return traco ? T_DASH : T_DOT;
   endfunction

   temporizador_morse #(.CNT_W(CNT_W)) u_tempo (
      .clk     (clk),
      .reset   (reset),
      .carga   (carga),
      .valor   (valor),
      .expirou (expirou)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q <= OCIOSO;
         sr_q     <= '0;
         indice_q <= '0;
         led_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         erro_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         sr_q     <= sr_d;
         indice_q <= indice_d;
         led_q    <= led_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         erro_q   <= erro_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      sr_d     = sr_q;
      indice_d = indice_q;
      led_d    = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      erro_d   = 1'b0;
      carga    = 1'b0;
      valor    = '0;
      unique case (estado_q)
         OCIOSO: begin
            if (start) begin
               if (codigo_valido(codigo)) begin
                  estado_d = MARCA;
                  sr_d     = codigo;
                  indice_d = '0;
                  led_d    = 1'b1;
                  busy_d   = 1'b1;
                  carga    = 1'b1;
                  valor    = dur_marca(codigo[4]);
               end else begin
                  erro_d = 1'b1;
               end
            end
         end
         MARCA: begin
            busy_d = 1'b1;
            led_d  = 1'b1;
            if (expirou) begin
               led_d = 1'b0;
               carga = 1'b1;
               if (indice_q < ULTIMO) begin
                  estado_d = ESPACO;
                  valor    = T_GAP;
               end else begin
                  estado_d = FIM;
                  valor    = T_CHAR;
               end
            end
         end
         ESPACO: begin
            busy_d = 1'b1;
            if (expirou) begin
               // Next symbol's length comes from the bit that becomes the MSB after the shift.
               estado_d = MARCA;
               sr_d     = {sr_q[3:0], 1'b0};
               indice_d = indice_q + 3'd1;
               led_d    = 1'b1;
               carga    = 1'b1;
               valor    = dur_marca(sr_q[3]);
            end
         end
         FIM: begin
            busy_d = 1'b1;
            if (expirou) begin
               estado_d = OCIOSO;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               indice_d = '0;
            end
         end
         default: estado_d = OCIOSO;
      endcase
`ifdef MORSE_ABORT_EN
      if (aborta && estado_q != OCIOSO) begin
         estado_d = OCIOSO;
         indice_d = '0;
         led_d    = 1'b0;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         erro_d   = 1'b1;
         carga    = 1'b1;
         valor    = '0;
      end
`endif
   end

   assign led    = led_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign erro   = erro_q;
   assign indice = indice_q;

endmodule

// File: tb/tb_sequenciador_morse.sv
// Randomized bench for sequenciador_morse against a per-cycle schedule model.
module tb_sequenciador_morse;

   localparam int U = 4;

   logic       clk = 1'b0;
   logic       reset, start, aborta;
   logic [4:0] codigo;
   logic       led, busy, done, erro;
   logic [2:0] indice;

   int n_chk = 0;
   int n_err = 0;

   // Expected outputs per cycle, packed as {led,busy,done,erro,indice}.
   logic [6:0] cur;
   logic [6:0] fila[$];
   logic [4:0] validos [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};

   always #5 clk = ~clk;

   sequenciador_morse #(.UNIT_CYCLES(U), .N_SIMBOLOS(5)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .codigo (codigo),
`ifdef MORSE_ABORT_EN
      .aborta (aborta),
`endif
      .led    (led),
      .busy   (busy),
      .done   (done),
      .erro   (erro),
      .indice (indice)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit e_valido(input logic [4:0] c);
      foreach (validos[i]) if (validos[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int len_esperado(input logic [4:0] c);
      int s = 7*U;
      for (int i = 0; i < 5; i++) s += c[i] ? 3*U : U;
      return s;
   endfunction

   function automatic void agenda(input logic [4:0] c);
      for (int i = 0; i < 5; i++) begin
         int m = c[4-i] ? 3*U : U;
         logic [2:0] ii = 3'(i);
         repeat (m) fila.push_back({2'b11, 2'b00, ii});
         if (i < 4) repeat (U) fila.push_back({2'b01, 2'b00, ii});
      end
      repeat (3*U) fila.push_back({2'b01, 2'b00, 3'd4});
      fila.push_back(7'b0010000);
   endfunction

   task automatic ciclo(input logic st, input logic [4:0] cod, input logic ab);
      start  = st;
      codigo = cod;
      aborta = ab;
      @(posedge clk);
      if (!cur[5]) begin
         if (st && e_valido(cod)) begin
            agenda(cod);
            cur = fila.pop_front();
         end else begin
            cur = st ? 7'b0001000 : 7'b0000000;
         end
`ifdef MORSE_ABORT_EN
      end else if (ab) begin
         fila.delete();
         cur = 7'b0001000;
`endif
      end else begin
         cur = fila.pop_front();
      end
      #1 chk("saida", {led, busy, done, erro, indice}, cur);
   endtask

   task automatic pulso_reset();
      #2 reset = 1'b1;
      #1 chk("reset_async", {led, busy, done, erro, indice}, 7'b0);
      fila.delete();
      cur = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Start one character, then measure busy length and done position; stray
   // start pulses only while the model says the DUT is busy.
   task automatic digito(input logic [4:0] c, input int exp_len);
      int n_busy = 0;
      int t_done = 0;
      ciclo(1'b1, c, 1'b0);
      if (busy) n_busy++;
      for (int k = 2; k <= 200 && t_done == 0; k++) begin
         ciclo(cur[5] ? 1'($urandom_range(0, 1)) : 1'b0, 5'($urandom), 1'b0);
         if (busy) n_busy++;
         if (done) t_done = k;
      end
      chk("busy_len", n_busy, exp_len);
      chk("done_at", t_done, exp_len + 1);
   endtask

   initial begin
      int n_done;
      reset  = 1'b1;
      start  = 1'b0;
      aborta = 1'b0;
      codigo = '0;
      cur    = '0;
      #3 chk("reset_init", {led, busy, done, erro, indice}, 7'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) ciclo(1'b0, 5'b0, 1'b0);

      digito(5'b11111, 88);
      digito(5'b00000, 48);
      digito(5'b00011, len_esperado(5'b00011));
      repeat (2) ciclo(1'b0, 5'b0, 1'b0);

      ciclo(1'b1, 5'b01010, 1'b0);
      ciclo(1'b0, 5'b0, 1'b0);
      ciclo(1'b1, 5'b10101, 1'b0);
      ciclo(1'b0, 5'b0, 1'b0);

      // Held start: characters chain with only the done cycle between them.
      n_done = 0;
      repeat (2*(len_esperado(5'b10000)+1)) begin
         ciclo(1'b1, 5'b10000, 1'b0);
         if (done) n_done++;
      end
      chk("held_dones", n_done, 2);
      repeat (3) ciclo(1'b0, 5'b0, 1'b0);

      ciclo(1'b1, 5'b11111, 1'b0);
      repeat (29) ciclo(1'b0, 5'($urandom), 1'b0);
      pulso_reset();
      digito(5'b11111, 88);

`ifdef MORSE_ABORT_EN
      ciclo(1'b1, 5'b11111, 1'b0);
      repeat (19) ciclo(1'b0, 5'b0, 1'b0);
      ciclo(1'b0, 5'b0, 1'b1);
      repeat (3) ciclo(1'b0, 5'b0, 1'b0);
`endif

      repeat (3000) begin
         logic st, ab;
         logic [4:0] cod;
         st  = ($urandom_range(0, 9) == 0);
         cod = $urandom_range(0, 1) ? validos[$urandom_range(0, 9)] : 5'($urandom);
         ab  = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 999) == 0) pulso_reset();
         ciclo(st, cod, ab);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
      $finish;
   end

endmodule
